serial_adder: RTL

//  Bit-serial WIDTH-bit adder. It computes a + b + cin one bit per clock, LSB

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 116 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Counter must hold WIDTH-1 without wrapping, including WIDTH=1.
    function automatic int cnt_width(input int width);
        return (width < 1) ? 1 : (($clog2(width + 1) < 1) ? 1 : $clog2(width + 1));
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single combinational full-adder cell; the only arithmetic in the serial adder.
module full_adder (
    output logic s,
    output logic c,
    input  logic x,
    input  logic y,
    input  logic ci
);

    assign s = x ^ y ^ ci;
    assign c = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder step per clock, LSB first,
// with a start/busy/done handshake and result registers held between runs.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;

    logic             w_s;
    logic             w_c;
    logic [WIDTH:0]   w_acc_cat;

    full_adder u_fa (
        .s  (w_s),
        .c  (w_c),
        .x  (r_opa[0]),
        .y  (r_opb[0]),
        .ci (r_carry)
    );

    // New sum bit enters at the MSB; slicing the concatenation keeps WIDTH=1 legal.
    assign w_acc_cat = {w_s, r_acc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc   <= w_acc_cat[WIDTH:1];
                    r_opa   <= r_opa >> 1;
                    r_opb   <= r_opb >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    // Results are registered together with entry to DONE so done and sum align.
                    if (r_cnt == LAST) begin
                        r_sum   <= w_acc_cat[WIDTH:1];
                        r_cout  <= w_c;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
